traffic_signal_monitor: RTL and testbench

- Independent receive-side checker for the four-approach intersection lamp bus (M1, M2, MT, S).
- Decodes lamp vectors back into phase numbers, checks phase order and per-phase dwell times, and latches the first fault with a code.
- Sits beside the signal controller on the same clk/reset. Its outputs feed the fail-safe/flash logic and the status registers.

---
 rtl/traffic_signal_monitor.sv | 160 ++++++++++++++++
 tb/tb_traffic_signal_monitor.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_signal_monitor.sv
// Receive-side lamp bus checker: phase decode, order/dwell checks, fault latch.
// Optional blinking red output under `TRAFFIC_MON_FLASH_RED_EN.
module traffic_signal_monitor #(
  parameter int DWELL_P0   = 8,
  parameter int DWELL_P1   = 3,
  parameter int DWELL_P2   = 6,
  parameter int DWELL_P3   = 3,
  parameter int DWELL_P4   = 4,
  parameter int DWELL_P5   = 3,
  parameter int FLASH_HALF = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] M1,
  input  logic [2:0] M2,
  input  logic [2:0] MT,
  input  logic [2:0] S,
  input  logic       clear_fault,
  output logic [2:0] phase,
  output logic       monitoring,
  output logic       fault,
  output logic [2:0] fault_code,
`ifdef TRAFFIC_MON_FLASH_RED_EN
  output logic [7:0] cycle_count,
  output logic       flash_red
`else
  output logic [7:0] cycle_count
`endif
);

  localparam logic [1:0] SYNC    = 2'd0;
  localparam logic [1:0] MONITOR = 2'd1;
  localparam logic [1:0] FAULT   = 2'd2;

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic [2:0] prev_ph;
  logic [2:0] cur_ph;
  logic [2:0] nxt_ph;
  logic [2:0] det;
  logic       lamps_ok;
  logic       same;

  function automatic logic onehot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  function automatic logic [3:0] dwell(input logic [2:0] p);
    logic [3:0] d;
    case (p)
      3'd0:    d = 4'(DWELL_P0);
      3'd1:    d = 4'(DWELL_P1);
      3'd2:    d = 4'(DWELL_P2);
      3'd3:    d = 4'(DWELL_P3);
      3'd4:    d = 4'(DWELL_P4);
      default: d = 4'(DWELL_P5);
    endcase
    return d;
  endfunction

  assign lamps_ok = onehot(M1) && onehot(M2)
                 && onehot(MT) && onehot(S);

  always_comb begin
    cur_ph = 3'd7;
    case ({M1, M2, MT, S})
      12'b001_001_100_100: cur_ph = 3'd0;
      12'b001_010_100_100: cur_ph = 3'd1;
      12'b001_100_001_100: cur_ph = 3'd2;
      12'b010_100_010_100: cur_ph = 3'd3;
      12'b100_100_100_001: cur_ph = 3'd4;
      12'b100_100_100_010: cur_ph = 3'd5;
      default:             cur_ph = 3'd7;
    endcase
  end

  assign nxt_ph  = (prev_ph == 3'd5) ? 3'd0 : prev_ph + 3'd1;
  assign same    = (cur_ph == prev_ph);
  assign cnt_inc = (cnt == 4'd15) ? cnt : cnt + 4'd1;

  // Priority chain makes the lowest code win.
  always_comb begin
    det = 3'd0;
    if (state != FAULT) begin
      if (!lamps_ok)
        det = 3'd1;
      else if (cur_ph == 3'd7)
        det = 3'd2;
      else if (!same) begin
        if (cur_ph != nxt_ph)
          det = 3'd3;
        else if (state == MONITOR && cnt != dwell(prev_ph))
          det = 3'd4;
      end else if (state == MONITOR && cnt_inc > dwell(cur_ph))
        det = 3'd5;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= SYNC;
      cnt         <= 4'd1;
      prev_ph     <= 3'd0;
      phase       <= 3'd0;
      fault_code  <= 3'd0;
      cycle_count <= 8'd0;
    end else begin
      phase <= cur_ph;
      if (cur_ph != 3'd7)
        prev_ph <= cur_ph;
      if (state == FAULT) begin
        if (clear_fault) begin
          state      <= SYNC;
          fault_code <= 3'd0;
          cnt        <= 4'd1;
        end
      end else if (det != 3'd0) begin
        state      <= FAULT;
        fault_code <= det;
      end else if (!same) begin
        cnt <= 4'd1;
        if (state == SYNC)
          state <= MONITOR;
        else if (prev_ph == 3'd5)
          cycle_count <= cycle_count + 8'd1;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

  assign monitoring = (state == MONITOR);
  assign fault      = (state == FAULT);

`ifdef TRAFFIC_MON_FLASH_RED_EN
  logic [7:0] blink;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash_red <= 1'b0;
      blink     <= 8'd0;
    end else if (state != FAULT && det != 3'd0) begin
      flash_red <= 1'b1;
      blink     <= 8'd0;
    end else if (state == FAULT && !clear_fault) begin
      if (blink == 8'(FLASH_HALF - 1)) begin
        blink     <= 8'd0;
        flash_red <= ~flash_red;
      end else begin
        blink <= blink + 8'd1;
      end
    end else begin
      flash_red <= 1'b0;
      blink     <= 8'd0;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Scoreboard bench for traffic_signal_monitor.
// Build with +define+TRAFFIC_MON_FLASH_RED_EN to cover flash_red too.
module tb_traffic_signal_monitor;

  logic       clk;
  logic       reset;
  logic [2:0] M1, M2, MT, S;
  logic       clear_fault;
  logic [2:0] phase;
  logic       monitoring;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;
  logic       flash_red;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic       mon;
    logic       flt;
    logic [2:0] code;
    logic [7:0] cc;
    logic       fl;
  } exp_t;

  exp_t sb[$];
  int   exp_cc = 0;
  int   nf = 0;
  int   dw[6] = '{8, 3, 6, 3, 4, 3};

  traffic_signal_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .M1          (M1),
    .M2          (M2),
    .MT          (MT),
    .S           (S),
    .clear_fault (clear_fault),
    .phase       (phase),
    .monitoring  (monitoring),
    .fault       (fault),
    .fault_code  (fault_code),
`ifdef TRAFFIC_MON_FLASH_RED_EN
    .cycle_count (cycle_count),
    .flash_red   (flash_red)
`else
    .cycle_count (cycle_count)
`endif
  );

`ifndef TRAFFIC_MON_FLASH_RED_EN
  assign flash_red = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] lp(input int p);
    logic [11:0] v;
    case (p)
      0:       v = 12'b001_001_100_100;
      1:       v = 12'b001_010_100_100;
      2:       v = 12'b001_100_001_100;
      3:       v = 12'b010_100_010_100;
      4:       v = 12'b100_100_100_001;
      default: v = 12'b100_100_100_010;
    endcase
    return v;
  endfunction

  task automatic step(input string tag, input logic [11:0] lamps,
                      input logic clr, input int ph, input logic mon,
                      input logic flt, input int code);
    exp_t e;
    exp_t o;
    @(negedge clk);
    {M1, M2, MT, S} = lamps;
    clear_fault = clr;
    e.tag  = tag;
    e.ph   = 3'(ph);
    e.mon  = mon;
    e.flt  = flt;
    e.code = 3'(code);
    e.cc   = 8'(exp_cc);
    if (flt) begin
      e.fl = ((nf / 4) % 2) == 0;
      nf++;
    end else begin
      e.fl = 1'b0;
      nf = 0;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    o = sb.pop_front();
    chk({o.tag, ".phase"}, 32'(phase), 32'(o.ph));
    chk({o.tag, ".mon"}, 32'(monitoring), 32'(o.mon));
    chk({o.tag, ".fault"}, 32'(fault), 32'(o.flt));
    chk({o.tag, ".code"}, 32'(fault_code), 32'(o.code));
    chk({o.tag, ".cc"}, 32'(cycle_count), 32'(o.cc));
`ifdef TRAFFIC_MON_FLASH_RED_EN
    chk({o.tag, ".flash"}, 32'(flash_red), 32'(o.fl));
`endif
  endtask

  task automatic hold(input string tag, input int p, input int n,
                      input logic mon);
    for (int k = 0; k < n; k++)
      step(tag, lp(p), 1'b0, p, mon, 1'b0, 0);
  endtask

  initial begin
    reset = 1'b1;
    clear_fault = 1'b0;
    {M1, M2, MT, S} = lp(0);
    #12;
    chk("rst.phase", 32'(phase), 0);
    chk("rst.mon", 32'(monitoring), 0);
    chk("rst.fault", 32'(fault), 0);
    chk("rst.code", 32'(fault_code), 0);
    chk("rst.cc", 32'(cycle_count), 0);
    chk("rst.flash", 32'(flash_red), 0);
    @(negedge clk);
    reset = 1'b0;

    // three legal cycles, then back into P0
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 6; p++)
        for (int k = 0; k < dw[p]; k++) begin
          if (c > 0 && p == 0 && k == 0) exp_cc++;
          step("legal", lp(p), 1'b0, p,
               !(c == 0 && p == 0), 1'b0, 0);
        end
    exp_cc++;
    hold("p0", 0, 8, 1'b1);
    hold("p1", 1, 3, 1'b1);
    hold("p2", 2, 2, 1'b1);

    // code 1: dark lamp, code holds through later lamps
    step("c1", {3'b000, lp(2)[8:0]}, 1'b0, 7, 1'b0, 1'b1, 1);
    for (int i = 0; i < 8; i++)
      step("c1hold", lp(i % 6), 1'b0, i % 6, 1'b0, 1'b1, 1);
    step("clr1", lp(2), 1'b1, 2, 1'b0, 1'b0, 0);

    // code 2: conflicting greens; clear taken with bad lamps still up
    step("c2", 12'b001_100_100_001, 1'b0, 7, 1'b0, 1'b1, 2);
    step("clr2", 12'b001_100_100_001, 1'b1, 7, 1'b0, 1'b0, 0);
    step("sync2", lp(3), 1'b0, 3, 1'b1, 1'b0, 0);

    // code 3: P0 -> P2; clear in MONITOR ignored
    hold("p3", 3, 2, 1'b1);
    hold("p4", 4, 2, 1'b1);
    step("clrign", lp(4), 1'b1, 4, 1'b1, 1'b0, 0);
    hold("p4", 4, 1, 1'b1);
    hold("p5", 5, 3, 1'b1);
    exp_cc++;
    hold("p0", 0, 8, 1'b1);
    step("c3", lp(2), 1'b0, 2, 1'b0, 1'b1, 3);
    step("frz", lp(5), 1'b0, 5, 1'b0, 1'b1, 3);
    step("frz", lp(0), 1'b0, 0, 1'b0, 1'b1, 3);
    step("clr3", lp(2), 1'b1, 2, 1'b0, 1'b0, 0);
    hold("sync3", 2, 1, 1'b0);
    step("resume", lp(3), 1'b0, 3, 1'b1, 1'b0, 0);

    // code 4: P0 left after 7
    hold("p3", 3, 2, 1'b1);
    hold("p4", 4, 4, 1'b1);
    hold("p5", 5, 3, 1'b1);
    exp_cc++;
    hold("p0", 0, 7, 1'b1);
    step("c4", lp(1), 1'b0, 1, 1'b0, 1'b1, 4);
    step("clr4", lp(1), 1'b1, 1, 1'b0, 1'b0, 0);
    hold("sync4", 1, 1, 1'b0);
    hold("p2", 2, 6, 1'b1);
    hold("p3", 3, 3, 1'b1);
    hold("p4", 4, 4, 1'b1);

    // code 5 on the 5th P4 sample
    step("c5", lp(4), 1'b0, 4, 1'b0, 1'b1, 5);

    // seq error and short dwell together: code 3 wins
    step("clr5", lp(4), 1'b1, 4, 1'b0, 1'b0, 0);
    hold("p5", 5, 2, 1'b1);
    step("prio", lp(1), 1'b0, 1, 1'b0, 1'b1, 3);
    step("clr6", lp(0), 1'b1, 0, 1'b0, 1'b0, 0);
    hold("sync6", 0, 2, 1'b0);

    // asynchronous reset mid-cycle
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.phase", 32'(phase), 0);
    chk("arst.cc", 32'(cycle_count), 0);
    chk("arst.mon", 32'(monitoring), 0);
    chk("arst.fault", 32'(fault), 0);
    @(negedge clk);
    reset = 1'b0;
    exp_cc = 0;
    nf = 0;
    hold("post", 0, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
